// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//
// Shared types and constants for the step sequencer controller.
//
// Contents:
//   note_t             4-bit note code. 0 is a rest and 1..8 are playable notes.
//   NOTE_REST          code stored and played for a silent step
//   NOTE_MAX           highest legal encoder position / note code
//   DEFAULT_NUM_STEPS  default sequence length used by step_sequencer_ctrl
//   seq_state_t        playback FSM states {STOP, PLAY}
//   sanitize_note()    maps a raw encoder position onto a legal note code
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef logic [3:0] note_t;

    localparam note_t NOTE_REST = 4'd0;
    localparam note_t NOTE_MAX  = 4'd8;

    localparam int DEFAULT_NUM_STEPS = 8;

    typedef enum logic {
        STOP = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    // The encoder can report 0 or 9..15 when it is out of its detent range.
    // Those positions are stored as rests, so the sequencer only ever plays
    // notes that exist.
    function automatic note_t sanitize_note(input logic [3:0] pos);
        note_t result;
        if ((pos == NOTE_REST) || (pos > NOTE_MAX)) begin
            result = NOTE_REST;
        end else begin
            result = note_t'(pos);
        end
        return result;
    endfunction

endpackage : seq_pkg

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns the raw, bouncing encoder pushbutton into a clean one-cycle press
// pulse.
//
// Pipeline:
//   1. A two-flop synchronizer brings the asynchronous button into clk.
//   2. The debounced level follows the synchronized sample only after
//      DEBOUNCE_CYCLES consecutive samples that differ from it. Any sample
//      that agrees with the current level restarts the count, so bounces
//      shorter than DEBOUNCE_CYCLES never change the level.
//   3. A rising edge of the debounced level produces a single press pulse.
//      Holding the button produces no further pulses.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset. It clears the synchronizer, the
//             level, the counter and any pending press.
//   button_i  raw pushbutton input (asynchronous)
//   press_o   one-cycle pulse, registered, on each accepted press
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The count holds the number of disagreeing samples already seen. The
    // sample that meets this value is the DEBOUNCE_CYCLES-th one in the run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sample;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    assign sample = sync_q[1];

    always_comb begin
        // NOTE: every signal assigned here gets a default first. A path that
        // leaves one unassigned would infer a latch.
        level_d = level_q;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Rising-edge detect on the debounced level. The press is taken from
        // the next-level value, so it registers in the same cycle the new
        // level is accepted.
        press_d = level_d & ~level_q;
    end

    // NOTE: state flops use non-blocking assignments only. Every flop then
    // samples pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], button_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule : button_debouncer

// File: rtl/step_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// step_sequencer_ctrl
//
// Step sequencer controller. The user programs a short note sequence with a
// rotary encoder and its pushbutton. While play_en is high, the sequence loops
// one step every TICKS_PER_STEP clocks.
//
// Editing:
//   Each debounced press writes the (sanitized) rotary_position into the step
//   at edit_index. write_ack pulses in the same cycle, and edit_index then
//   advances, wrapping at the end of the sequence. Editing works in both
//   STOP and PLAY.
//
// Playback:
//   STOP -> PLAY on play_en=1. The first PLAY cycle already presents step 0
//   with a strobe. Each step lasts TICKS_PER_STEP cycles. note is latched at
//   the start of the step and held for the whole step, so an edit to the
//   step that is playing is heard on the next pass. gate is high for the
//   first GATE_TICKS cycles of any non-rest step. PLAY -> STOP on play_en=0
//   silences the outputs and rewinds to step 0, and the programmed sequence
//   is kept.
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   button           raw encoder pushbutton (asynchronous, bouncing)
//   rotary_position  encoder note selection, legal values 1..8
//   play_en          1 = play, 0 = stop (level)
//   note             note of the current step, 0 = rest
//   note_strobe      one-cycle pulse at the start of every step
//   gate             note-on window within the step
//   step_index       step currently being played
//   edit_index       step the next press will write
//   write_ack        one-cycle pulse when a step is written
//
// NUM_STEPS must be a power of two (2..16) so that the step and edit indices
// wrap naturally. GATE_TICKS must be below TICKS_PER_STEP.
// -----------------------------------------------------------------------------
module step_sequencer_ctrl
    import seq_pkg::*;
#(
    parameter int NUM_STEPS       = DEFAULT_NUM_STEPS,
    parameter int TICKS_PER_STEP  = 3_000_000,
    parameter int GATE_TICKS      = 1_500_000,
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         button,
    input  logic [3:0]                   rotary_position,
    input  logic                         play_en,
    output logic [3:0]                   note,
    output logic                         note_strobe,
    output logic                         gate,
    output logic [$clog2(NUM_STEPS)-1:0] step_index,
    output logic [$clog2(NUM_STEPS)-1:0] edit_index,
    output logic                         write_ack
);

    localparam int STEP_W = $clog2(NUM_STEPS);
    localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [TICK_W-1:0] GATE_LIMIT = TICK_W'(GATE_TICKS);

    // -------------------------------------------------------------------------
    // Button path
    // -------------------------------------------------------------------------
    logic press;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk      (clk),
        .rst      (rst),
        .button_i (button),
        .press_o  (press)
    );

    // -------------------------------------------------------------------------
    // Step memory and edit pointer
    // -------------------------------------------------------------------------
    note_t             mem_q [NUM_STEPS];
    logic [STEP_W-1:0] edit_q;

    // The playback logic reads mem_q combinationally and loads the result at
    // the same edge a write lands. A load and a write to the same step in one
    // cycle therefore take the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the step memory is a reset flop array, not a RAM, so that
            // a fresh reset always replays as silence. Inferred RAMs cannot
            // be cleared in a single cycle.
            for (int i = 0; i < NUM_STEPS; i++) begin
                mem_q[i] <= NOTE_REST;
            end
            edit_q <= '0;
        end else if (press) begin
            mem_q[edit_q] <= sanitize_note(rotary_position);
            edit_q        <= edit_q + STEP_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Playback FSM
    // -------------------------------------------------------------------------
    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] step_next;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    note_t             note_q;
    note_t             note_d;
    logic              strobe_q;
    logic              strobe_d;

    // Power-of-two NUM_STEPS: the increment wraps NUM_STEPS-1 -> 0 by itself.
    assign step_next = step_q + STEP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STOP;
            step_q   <= '0;
            tick_q   <= '0;
            note_q   <= NOTE_REST;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            note_q   <= note_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        tick_d   = tick_q;
        note_d   = note_q;
        strobe_d = 1'b0;

        unique case (state_q)
            STOP: begin
                // Keep the outputs parked at silence on step 0.
                step_d = '0;
                tick_d = '0;
                note_d = NOTE_REST;
                if (play_en) begin
                    // Start presenting step 0 right away, so the first PLAY
                    // cycle is already a step start.
                    state_d  = PLAY;
                    note_d   = mem_q[0];
                    strobe_d = 1'b1;
                end
            end

            PLAY: begin
                if (!play_en) begin
                    state_d = STOP;
                    step_d  = '0;
                    tick_d  = '0;
                    note_d  = NOTE_REST;
                end else if (tick_q == TICK_LAST) begin
                    step_d   = step_next;
                    tick_d   = '0;
                    note_d   = mem_q[step_next];
                    strobe_d = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            default: begin
                state_d = STOP;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // In STOP, note_q is a rest and tick_q is zero. The state term keeps gate
    // low there in any case.
    assign gate        = (state_q == PLAY) && (tick_q < GATE_LIMIT) && (note_q != NOTE_REST);
    assign note        = note_q;
    assign note_strobe = strobe_q;
    assign step_index  = step_q;
    assign edit_index  = edit_q;
    assign write_ack   = press;

endmodule : step_sequencer_ctrl

// File: tb/tb_step_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer_ctrl
//
// Directed bench for step_sequencer_ctrl with NUM_STEPS=4, TICKS_PER_STEP=4,
// GATE_TICKS=2 and DEBOUNCE_CYCLES=3. Inputs are driven and outputs sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_step_sequencer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [3:0] rotary_position;
    logic       play_en;
    logic [3:0] note;
    logic       note_strobe;
    logic       gate;
    logic [1:0] step_index;
    logic [1:0] edit_index;
    logic       write_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    step_sequencer_ctrl #(
        .NUM_STEPS       (4),
        .TICKS_PER_STEP  (4),
        .GATE_TICKS      (2),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .button          (button),
        .rotary_position (rotary_position),
        .play_en         (play_en),
        .note            (note),
        .note_strobe     (note_strobe),
        .gate            (gate),
        .step_index      (step_index),
        .edit_index      (edit_index),
        .write_ack       (write_ack)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int exp_note, input int exp_strobe,
                                 input int exp_gate, input int exp_step);
        check({tag, "_note"},   note,        exp_note);
        check({tag, "_strobe"}, note_strobe, exp_strobe);
        check({tag, "_gate"},   gate,        exp_gate);
        check({tag, "_step"},   step_index,  exp_step);
    endtask

    // Clean press: hold the button for 10 cycles, then release for 8. Expect
    // one write_ack, 4-5 cycles after the press, and edit_index at exp_edit.
    task automatic clean_press(input logic [3:0] pos, input int exp_edit);
        int lat;
        int acks;
        lat  = 0;
        acks = 0;
        rotary_position = pos;
        button          = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (write_ack) begin
                acks++;
                if (lat == 0) lat = i;
            end
        end
        check("press_latency_ok", int'(lat >= 4 && lat <= 5), 1);
        button = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (write_ack) acks++;
        end
        check("press_ack_count", acks, 1);
        check("press_edit_index", edit_index, exp_edit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_mem [4];
        int exp_note;
        int tk;
        int st;
        int acks;
        int lat;
        int ack_step;

        rst             = 1'b1;
        button          = 1'b0;
        rotary_position = 4'd0;
        play_en         = 1'b0;

        // ---------------- reset and idle ----------------
        repeat (3) @(negedge clk);
        check_outputs("reset", 0, 0, 0, 0);
        check("reset_edit", edit_index, 0);
        check("reset_ack", write_ack, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs("idle", 0, 0, 0, 0);
        check("idle_edit", edit_index, 0);
        check("idle_ack", write_ack, 0);

        // ---------------- four clean presses: 3,5,0,9 ----------------
        clean_press(4'd3, 1);
        clean_press(4'd5, 2);
        clean_press(4'd0, 3);
        clean_press(4'd9, 0);

        // ---------------- bouncing button ----------------
        // Rewrites step 0 with 3 again, so the sequence stays {3,5,0,0}.
        rotary_position = 4'd3;
        acks = 0;
        lat  = 0;
        for (int seg = 0; seg < 10; seg++) begin
            button = (seg % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                if (write_ack) acks++;
            end
        end
        check("bounce_no_ack", acks, 0);
        button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (write_ack) begin
                acks++;
                if (lat == 0) lat = i;
            end
        end
        check("bounce_latency_ok", int'(lat >= 4 && lat <= 5), 1);
        button = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (write_ack) acks++;
        end
        check("bounce_ack_count", acks, 1);
        check("bounce_edit_index", edit_index, 1);

        // ---------------- play {3,5,0,0}, edit step 1 while it plays --------
        exp_mem[0] = 3;
        exp_mem[1] = 5;
        exp_mem[2] = 0;
        exp_mem[3] = 0;
        exp_note = 0;
        acks     = 0;
        ack_step = -1;
        play_en  = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            tk = (k - 1) % 4;
            st = ((k - 1) / 4) % 4;
            if (tk == 0) exp_note = exp_mem[st];
            check_outputs("play", exp_note, int'(tk == 0), int'(tk < 2 && exp_note != 0), st);
            if (write_ack) begin
                acks++;
                ack_step = step_index;
            end
            // Press starts at the top of the second pass and is accepted
            // while step 1 is playing.
            if (k == 17) begin
                rotary_position = 4'd7;
                button          = 1'b1;
            end
            // Step 1 of this pass has been loaded with 5. The next load of
            // step 1 must see 7.
            if (k == 24) exp_mem[1] = 7;
            if (k == 27) button = 1'b0;
        end
        check("edit_ack_count", acks, 1);
        check("edit_ack_step", ack_step, 1);
        check("edit_index_after", edit_index, 2);

        // ---------------- stop mid step 2, then restart ----------------
        play_en = 1'b0;
        @(negedge clk);
        check_outputs("stop", 0, 0, 0, 0);
        check("stop_edit", edit_index, 2);
        repeat (3) begin
            @(negedge clk);
            check_outputs("stopped", 0, 0, 0, 0);
        end
        play_en = 1'b1;
        @(negedge clk);
        check_outputs("restart", 3, 1, 1, 0);
        @(negedge clk);
        check_outputs("restart_t1", 3, 0, 1, 0);

        // ---------------- reset mid-debounce with play_en held ----------------
        rotary_position = 4'd4;
        button          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("rst_mid", 0, 0, 0, 0);
        check("rst_mid_ack", write_ack, 0);
        check("rst_mid_edit", edit_index, 0);
        button = 1'b0;
        @(negedge clk);
        check("rst_hold_ack", write_ack, 0);
        rst = 1'b0;
        @(negedge clk);
        // Memory was cleared, so step 0 is a rest.
        check_outputs("rst_play", 0, 1, 0, 0);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (write_ack) acks++;
        end
        check("rst_no_write", acks, 0);
        check("rst_edit_after", edit_index, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_step_sequencer_ctrl
